vga_tile_store: RTL



---
 rtl/vga_pkg.sv | 17 +
 rtl/vga_chan_expand.sv | 20 ++
 rtl/vga_tile_store.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA tile framebuffer: command encodings,
// output channel width and the command FSM states.
package vga_pkg;

  localparam int OUT_W = 4;

  localparam logic [1:0] OP_APPEND = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_SETCUR = 2'b10;
  localparam logic [1:0] OP_FILL   = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

endpackage

// File: rtl/vga_chan_expand.sv
// Widens a CH-bit colour channel to OUT_W bits by repeating the field
// MSB-first and truncating, so full-scale input maps to full-scale output.
module vga_chan_expand
  import vga_pkg::*;
#(
  parameter int CH = 2
) (
  input  logic [CH-1:0]    chan_i,
  output logic [OUT_W-1:0] chan_o
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    chan_o = '0;
    for (int i = 0; i < OUT_W; i++) begin
      chan_o[OUT_W-1-i] = chan_i[CH-1-(i % CH)];
    end
  end

endmodule

// File: rtl/vga_tile_store.sv
// PW x PH tile framebuffer: valid/ready command port (append, write, set
// cursor, fill) and a two-stage scaled read pipeline for the VGA scan side.
module vga_tile_store
  import vga_pkg::*;
#(
  parameter int PW         = 40,
  parameter int PH         = 30,
  parameter int CH         = 2,
  parameter int SCALE_LOG2 = 4,
  localparam int N         = PW * PH,
  localparam int AW        = $clog2(N)
) (
  input  logic          clk_50,
  input  logic          reset,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [1:0]    wr_op,
  input  logic [AW-1:0] wr_addr,
  input  logic [11:0]   wr_rgb,
  input  logic          rd_en,
  input  logic [8:0]    rd_row,
  input  logic [9:0]    rd_col,
  output logic [3:0]    rd_r,
  output logic [3:0]    rd_g,
  output logic [3:0]    rd_b,
  output logic [AW-1:0] cursor,
  output logic          wrap_pulse,
  output logic          busy
);

  localparam int            DW    = 3 * CH;
  localparam logic [AW-1:0] LAST  = AW'(N - 1);
  localparam logic [AW:0]   N_EXT = (AW + 1)'(N);

  logic [DW-1:0] mem [N];

  state_t        state_q, state_d;
  logic [AW-1:0] cursor_q, cursor_d;
  logic [AW-1:0] fill_addr_q, fill_addr_d;
  logic [DW-1:0] fill_rgb_q, fill_rgb_d;
  logic          wrap_q, wrap_d;

  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] wr_word;
  logic          addr_ok;

  assign wr_word  = {wr_rgb[11 -: CH], wr_rgb[7 -: CH], wr_rgb[3 -: CH]};
  assign addr_ok  = {1'b0, wr_addr} < N_EXT;
  assign wr_ready = (state_q == IDLE);
  assign busy     = (state_q == FILL);

  always_comb begin
    state_d     = state_q;
    cursor_d    = cursor_q;
    fill_addr_d = fill_addr_q;
    fill_rgb_d  = fill_rgb_q;
    wrap_d      = 1'b0;
    we          = 1'b0;
    waddr       = cursor_q;
    wdata       = wr_word;
    case (state_q)
      IDLE: begin
        if (wr_valid) begin
          case (wr_op)
            OP_APPEND: begin
              we       = 1'b1;
              waddr    = cursor_q;
              wrap_d   = (cursor_q == LAST);
              cursor_d = (cursor_q == LAST) ? '0 : cursor_q + 1'b1;
            end
            OP_WRITE: begin
              we    = addr_ok;
              waddr = wr_addr;
            end
            OP_SETCUR: cursor_d = addr_ok ? wr_addr : '0;
            default: begin
              fill_rgb_d  = wr_word;
              fill_addr_d = '0;
              state_d     = FILL;
            end
          endcase
        end
      end
      FILL: begin
        we    = 1'b1;
        waddr = fill_addr_q;
        wdata = fill_rgb_q;
        if (fill_addr_q == LAST) begin
          state_d     = IDLE;
          cursor_d    = '0;
          fill_addr_d = '0;
        end else begin
          fill_addr_d = fill_addr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset enters FILL with colour 0, so the map is cleared in N cycles.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q     <= FILL;
      cursor_q    <= '0;
      fill_addr_q <= '0;
      fill_rgb_q  <= '0;
      wrap_q      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all registers update together.
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      fill_addr_q <= fill_addr_d;
      fill_rgb_q  <= fill_rgb_d;
      wrap_q      <= wrap_d;
    end
  end

  assign cursor     = cursor_q;
  assign wrap_pulse = wrap_q;

  // Read address: scale screen coordinates down to tile coordinates.
  logic [31:0]   tx32, ty32;
  logic          in_range;
  logic [AW-1:0] rd_addr;

  always_comb begin
    tx32     = 32'(rd_col >> SCALE_LOG2);
    ty32     = 32'(rd_row >> SCALE_LOG2);
    in_range = (tx32 < 32'(PW)) && (ty32 < 32'(PH));
    rd_addr  = in_range ? AW'(ty32 * 32'(PW) + tx32) : '0;
  end

  logic [DW-1:0] rd_data_q;

  // NOTE: the RAM array and its read register have no reset so they map to a macro; the reset fill clears contents.
  always_ff @(posedge clk_50) begin
    if (we && !reset) mem[waddr] <= wdata;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  logic [3:0] exp_r, exp_g, exp_b;

  vga_chan_expand #(.CH(CH)) u_exp_r (.chan_i(rd_data_q[3*CH-1 -: CH]), .chan_o(exp_r));
  vga_chan_expand #(.CH(CH)) u_exp_g (.chan_i(rd_data_q[2*CH-1 -: CH]), .chan_o(exp_g));
  vga_chan_expand #(.CH(CH)) u_exp_b (.chan_i(rd_data_q[CH-1:0]),       .chan_o(exp_b));

  logic       range_q;
  logic [3:0] rd_r_q, rd_g_q, rd_b_q;

  always_ff @(posedge clk_50) begin
    if (reset) begin
      range_q <= 1'b0;
      rd_r_q  <= '0;
      rd_g_q  <= '0;
      rd_b_q  <= '0;
    end else if (rd_en) begin
      range_q <= in_range;
      rd_r_q  <= range_q ? exp_r : 4'h0;
      rd_g_q  <= range_q ? exp_g : 4'h0;
      rd_b_q  <= range_q ? exp_b : 4'h0;
    end
  end

  assign rd_r = rd_r_q;
  assign rd_g = rd_g_q;
  assign rd_b = rd_b_q;

endmodule
